// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter in front of a single-port synchronous RAM; every access takes 4 cycles (IDLE, ACC, RESP, DONE).
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous requests; otherwise the CPU always wins a tie.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              ram_r_en,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_w_data,
   input  logic [DATA_W-1:0] ram_r_data,
   output logic [1:0]        owner
);

   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   typedef enum logic [1:0] {IDLE, ACC, RESP, DONE} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

   state_t            state, state_nxt;
   acc_t              cur, cur_nxt;
   acc_t              cpu_acc_c, dma_acc_c;
   logic [1:0]        owner_nxt;
   logic              r_en_nxt, w_en_nxt;
   logic              cpu_ack_nxt, dma_ack_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt, dma_rdata_nxt;
   logic              grant_dma_c;

   assign cpu_acc_c = {cpu_we, cpu_addr, cpu_wdata};
   assign dma_acc_c = {dma_we, dma_addr, dma_wdata};

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers who was granted last; resets to DMA so the first tie goes to the CPU.
   logic last_dma;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_dma <= 1'b1;
      end else if (state == IDLE && (cpu_req || dma_req)) begin
         last_dma <= grant_dma_c;
      end
   end

   assign grant_dma_c = dma_req && (!cpu_req || !last_dma);
`else
   assign grant_dma_c = dma_req && !cpu_req;
`endif

   // Next-state and next-output logic; every register is updated from these values.
   always_comb begin
      state_nxt     = state;
      cur_nxt       = cur;
      owner_nxt     = owner;
      r_en_nxt      = 1'b0;
      w_en_nxt      = 1'b0;
      cpu_ack_nxt   = 1'b0;
      dma_ack_nxt   = 1'b0;
      cpu_rdata_nxt = cpu_rdata;
      dma_rdata_nxt = dma_rdata;
      case (state)
         IDLE: begin
            if (cpu_req || dma_req) begin
               state_nxt = ACC;
               owner_nxt = grant_dma_c ? OWN_DMA : OWN_CPU;
               cur_nxt   = grant_dma_c ? dma_acc_c : cpu_acc_c;
               r_en_nxt  = !cur_nxt.we;
               w_en_nxt  = cur_nxt.we;
            end
         end
         ACC: begin
            state_nxt = RESP;
         end
         RESP: begin
            state_nxt = DONE;
            if (owner == OWN_DMA) begin
               dma_ack_nxt = 1'b1;
               if (!cur.we) dma_rdata_nxt = ram_r_data;
            end else begin
               cpu_ack_nxt = 1'b1;
               if (!cur.we) cpu_rdata_nxt = ram_r_data;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            owner_nxt = OWN_IDLE;
         end
         default: begin
            state_nxt = IDLE;
            owner_nxt = OWN_IDLE;
         end
      endcase
   end

   // State and all outputs are flops; ram_addr/ram_w_data come straight from the latched request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cur       <= '0;
         owner     <= OWN_IDLE;
         ram_r_en  <= 1'b0;
         ram_w_en  <= 1'b0;
         cpu_ack   <= 1'b0;
         dma_ack   <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         state     <= state_nxt;
         cur       <= cur_nxt;
         owner     <= owner_nxt;
         ram_r_en  <= r_en_nxt;
         ram_w_en  <= w_en_nxt;
         cpu_ack   <= cpu_ack_nxt;
         dma_ack   <= dma_ack_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         dma_rdata <= dma_rdata_nxt;
      end
   end

   assign ram_addr   = cur.addr;
   assign ram_w_data = cur.wdata;

   a_strobe_excl: assert property (@(posedge clk) disable iff (!reset) !(ram_r_en && ram_w_en));
   a_owner_legal: assert property (@(posedge clk) disable iff (!reset) owner != 2'b11);
   a_ack_excl:    assert property (@(posedge clk) disable iff (!reset) !(cpu_ack && dma_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants, RAM strobes, acks and read data.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int CPU = 0;
   localparam int DMA = 1;

   logic              clk;
   logic              reset;
   logic              cpu_req, dma_req, cpu_we, dma_we;
   logic [ADDR_W-1:0] cpu_addr, dma_addr, ram_addr;
   logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_w_data, ram_r_data;
   logic              cpu_ack, dma_ack, ram_r_en, ram_w_en;
   logic [1:0]        owner;

   typedef struct {
      int                who;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
      int                g;
   } grant_t;

   grant_t            sb[$];
   int                dut_log[$];
   logic [DATA_W-1:0] ram     [DEPTH];
   bit                ram_wr  [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                ref_wr  [DEPTH];
   logic [DATA_W-1:0] ref_rd  [2];
   bit                busy    [2];
   int  checks      = 0;
   int  failures    = 0;
   int  cyc         = 0;
   int  next_free   = 0;
   int  last_g      = 0;
   int  cpu_ack_cyc = -1;
   int  dma_ack_cyc = -1;
   bit  last_dma    = 1'b1;
   bit  persist     = 1'b0;
   bit  rand_on     = 1'b0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
      .ram_w_data(ram_w_data), .ram_r_data(ram_r_data), .owner(owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(32'(a) * 32'd40503 + 32'h1234);
   endfunction

   // Synchronous RAM: read data appears one cycle after ram_r_en.
   always @(posedge clk) begin
      if (ram_r_en) ram_r_data <= ram_wr[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
      if (ram_w_en) begin
         ram[ram_addr]    <= ram_w_data;
         ram_wr[ram_addr] <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic raise(input int who, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
      if (who == CPU) begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end else begin
         dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      end
      busy[who] = 1'b1;
   endtask

   task automatic raise_rand(input int who);
      raise(who, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(32, 95)), DATA_W'($urandom));
   endtask

   // Advance to the sample point of the next cycle; requesters drop or renew req on their ack.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_ack && busy[CPU]) begin
         if (persist || (rand_on && $urandom_range(0, 3) == 0)) raise_rand(CPU);
         else begin cpu_req = 1'b0; busy[CPU] = 1'b0; end
      end
      if (dma_ack && busy[DMA]) begin
         if (persist || (rand_on && $urandom_range(0, 3) == 0)) raise_rand(DMA);
         else begin dma_req = 1'b0; busy[DMA] = 1'b0; end
      end
   endtask

   // Reference model: the RAM is free every 4th cycle after a grant; requests present then are arbitrated.
   task automatic eval();
      if (reset && cyc >= next_free && (cpu_req || dma_req)) begin
         int     w;
         grant_t e;
         if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = last_dma ? CPU : DMA;
`else
            w = CPU;
`endif
         end else begin
            w = cpu_req ? CPU : DMA;
         end
         last_dma = (w == DMA);
         e.who   = w;
         e.we    = (w == CPU) ? cpu_we : dma_we;
         e.addr  = (w == CPU) ? cpu_addr : dma_addr;
         e.wdata = (w == CPU) ? cpu_wdata : dma_wdata;
         e.rdata = ref_wr[e.addr] ? ref_mem[e.addr] : init_val(e.addr);
         e.g     = cyc;
         if (e.we) begin
            ref_mem[e.addr] = e.wdata;
            ref_wr[e.addr]  = 1'b1;
         end else begin
            ref_rd[w] = e.rdata;
         end
         sb.push_back(e);
         last_g    = cyc;
         next_free = cyc + 4;
      end
   endtask

   task automatic step();
      tick();
      eval();
   endtask

   task automatic issue(input int who, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
      tick();
      raise(who, we, a, d);
      eval();
   endtask

   task automatic wait_quiet(input int budget);
      int n = 0;
      while ((busy[CPU] || busy[DMA] || sb.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk("quiet_timeout", 32'(n >= budget), 32'd0);
   endtask

   // Monitor: pops the scoreboard as each access completes and checks every output every cycle.
   initial begin : monitor
      logic [DATA_W-1:0] exp_rd [2];
      logic [1:0]        prev_owner;
      logic [1:0]        e_own;
      grant_t            h;
      bit                e_r, e_w, e_ca, e_da;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      prev_owner = 2'b00;
      forever begin
         @(posedge clk);
         #3;
         if (cpu_ack) cpu_ack_cyc = cyc;
         if (dma_ack) dma_ack_cyc = cyc;
         if (!reset) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            prev_owner = 2'b00;
            chk("rst_owner", 32'(owner), 32'd0);
            chk("rst_strobes", 32'({ram_r_en, ram_w_en}), 32'd0);
            chk("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
            chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
         end else begin
            e_own = 2'b00; e_r = 1'b0; e_w = 1'b0; e_ca = 1'b0; e_da = 1'b0;
            if (sb.size() > 0 && cyc > sb[0].g && cyc <= sb[0].g + 3) begin
               h = sb[0];
               e_own = (h.who == CPU) ? 2'b01 : 2'b10;
               if (cyc == h.g + 1) begin
                  e_r = !h.we;
                  e_w = h.we;
                  chk("ram_addr", 32'(ram_addr), 32'(h.addr));
                  if (h.we) chk("ram_w_data", 32'(ram_w_data), 32'(h.wdata));
               end
               if (cyc == h.g + 3) begin
                  if (h.who == CPU) e_ca = 1'b1;
                  else e_da = 1'b1;
                  if (!h.we) exp_rd[h.who] = h.rdata;
                  void'(sb.pop_front());
               end
            end
            chk("owner", 32'(owner), 32'(e_own));
            chk("ram_r_en", 32'(ram_r_en), 32'(e_r));
            chk("ram_w_en", 32'(ram_w_en), 32'(e_w));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_ca));
            chk("dma_ack", 32'(dma_ack), 32'(e_da));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[CPU]));
            chk("dma_rdata", 32'(dma_rdata), 32'(exp_rd[DMA]));
            if (owner != 2'b00 && prev_owner == 2'b00) dut_log.push_back(owner == 2'b01 ? CPU : DMA);
            prev_owner = owner;
         end
      end
   end

   initial begin : main
      int                n;
      int                g0;
      int                cpu_done;
      int                tie_start;
      int                exp_tie [3];
      logic [DATA_W-1:0] saved_dma;
`ifdef ARB_ROUND_ROBIN_EN
      exp_tie = '{CPU, DMA, CPU};
`else
      exp_tie = '{CPU, CPU, CPU};
`endif
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      busy[CPU] = 1'b0; busy[DMA] = 1'b0;
      ref_rd[CPU] = '0; ref_rd[DMA] = '0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ram_addr", 32'(ram_addr), 32'd0);
      chk("reset_ram_w_data", 32'(ram_w_data), 32'd0);
      reset = 1'b1;
      next_free = cyc;

      // CPU write then read-back of 0x010.
      issue(CPU, 1'b1, 12'h010, 16'hBEEF);
      g0 = last_g;
      wait_quiet(40);
      chk("wr_ack_latency", 32'(cpu_ack_cyc - g0), 32'd3);
      issue(CPU, 1'b0, 12'h010, 16'h0000);
      g0 = last_g;
      wait_quiet(40);
      chk("rd_ack_latency", 32'(cpu_ack_cyc - g0), 32'd3);
      chk("rd_beef", 32'(cpu_rdata), 32'h0000BEEF);

      // Reset so the last-grant memory starts at DMA, then three back-to-back ties.
      tick();
      reset = 1'b0;
      sb.delete();
      last_dma = 1'b1;
      ref_rd[CPU] = '0; ref_rd[DMA] = '0;
      tick();
      tick();
      reset = 1'b1;
      next_free = cyc;
      tie_start = dut_log.size();
      persist = 1'b1;
      tick();
      raise(CPU, 1'b0, 12'h020, 16'h0);
      raise(DMA, 1'b0, 12'h021, 16'h0);
      eval();
      n = 0;
      while (last_g - cyc > -1 && n < 1) n++;
      n = 0;
      while (cyc < last_g + 8 && n < 40) begin
         step();
         n++;
      end
      persist = 1'b0;
      wait_quiet(60);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("tie_grant%0d", i),
             32'((tie_start + i < dut_log.size()) ? dut_log[tie_start + i] : 9), 32'(exp_tie[i]));
      end

      // DMA write raised while a CPU read is in ACC waits for the CPU's DONE.
      saved_dma = ref_rd[DMA];
      issue(CPU, 1'b0, 12'h010, 16'h0);
      g0 = last_g;
      tick();
      raise(DMA, 1'b1, 12'h0FF, 16'hA5C3);
      eval();
      wait_quiet(40);
      chk("cpu_ack_lat", 32'(cpu_ack_cyc - g0), 32'd3);
      chk("dma_after_cpu", 32'(dma_ack_cyc - cpu_ack_cyc), 32'd4);
      chk("dma_rdata_kept", 32'(dma_rdata), 32'(saved_dma));

      // Reset during RESP of a CPU read, request held through reset.
      issue(CPU, 1'b0, 12'h010, 16'h0);
      cpu_done = cpu_ack_cyc;
      tick();
      eval();
      tick();
      reset = 1'b0;
      sb.delete();
      last_dma = 1'b1;
      ref_rd[CPU] = '0; ref_rd[DMA] = '0;
      #1;
      chk("abort_owner", 32'(owner), 32'd0);
      chk("abort_strobes", 32'({ram_r_en, ram_w_en}), 32'd0);
      chk("abort_ack", 32'(cpu_ack), 32'd0);
      chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("abort_ram_addr", 32'(ram_addr), 32'd0);
      tick();
      tick();
      chk("abort_no_ack", 32'(cpu_ack_cyc), 32'(cpu_done));
      reset = 1'b1;
      next_free = cyc;
      eval();
      g0 = last_g;
      wait_quiet(40);
      chk("rearb_ack_lat", 32'(cpu_ack_cyc - g0), 32'd3);
      chk("rearb_rdata", 32'(cpu_rdata), 32'h0000BEEF);

      // Random traffic from both requesters.
      rand_on = 1'b1;
      repeat (800) begin
         tick();
         if (!busy[CPU] && $urandom_range(0, 2) == 0) raise_rand(CPU);
         if (!busy[DMA] && $urandom_range(0, 2) == 0) raise_rand(DMA);
         eval();
      end
      rand_on = 1'b0;
      wait_quiet(100);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
